// File: rtl/counter_hex_display_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_hex_display_if
// Description : Signal bundle between the upstream 4-bit counter / display
//               consumer and counter_hex_display.
//               master : drives QN, CO, UPDN, CLR_HI; observes HI, WRAP, SEG, AN
//               slave  : the display stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_hex_display_if;
    logic [3:0] QN;      // low nibble from upstream counter
    logic       CO;      // upstream carry/borrow, level
    logic       UPDN;    // upstream direction: 1 = up, 0 = down
    logic       CLR_HI;  // synchronous clear of the high nibble
    logic [3:0] HI;      // extended high nibble
    logic       WRAP;    // one-cycle pulse when HI wraps
    logic [6:0] SEG;     // {g,f,e,d,c,b,a}, active-low
    logic [1:0] AN;      // digit enables, active-low

    modport master (
        output QN, CO, UPDN, CLR_HI,
        input  HI, WRAP, SEG, AN
    );

    modport slave (
        input  QN, CO, UPDN, CLR_HI,
        output HI, WRAP, SEG, AN
    );
endinterface
`default_nettype wire

// File: rtl/counter_hex_display.sv
`default_nettype none
// ============================================================================
// Module      : counter_hex_display
// Description : Downstream stage of a 4-bit up/down counter. Extends the count
//               with a high nibble driven by CO rising edges and scans the
//               pair {HI, QN} onto a 2-digit, active-low 7-segment display.
// Ports       : CLK  - system clock, rising edge
//               MR   - asynchronous active-high master reset
//               bus  - counter_hex_display_if.slave
//                      QN/CO/UPDN/CLR_HI in, HI/WRAP/SEG/AN out
// Parameters  : SCAN_DIV - clock cycles each digit is held (2..255)
// Build macro : LEAD_BLANK_EN - when defined, the high digit is blanked while
//               HI == 0; the low digit is never blanked.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_hex_display #(
    parameter int SCAN_DIV = 4
) (
    input  wire logic            CLK,
    input  wire logic            MR,
    counter_hex_display_if.slave bus
);

    localparam int         c_PRE_W   = 8;
    localparam [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
    localparam [6:0]       c_SEG_OFF = 7'h7F;
    localparam [1:0]       c_AN_OFF  = 2'b11;
    localparam [1:0]       c_AN_LO   = 2'b10;
    localparam [1:0]       c_AN_HI   = 2'b01;

    // Hex to active-low {g..a} segment pattern
    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [3:0]         r_q;
    logic               r_co_d;
    logic [3:0]         r_hi;
    logic               r_wrap;
    logic [c_PRE_W-1:0] r_pre;
    logic               r_sel;
    logic [1:0]         r_an;
    logic [6:0]         r_seg;

    logic               w_ev;
    logic               w_tick;
    logic [1:0]         w_hi_an;
    logic [6:0]         w_hi_seg;

    // A CO held high yields only one event; CO high at reset release is an edge
    // because the history register comes out of reset at 0.
    assign w_ev   = bus.CO & ~r_co_d;
    assign w_tick = (r_pre == c_PRE_LAST);

    // Pattern loaded when the scan moves onto the high digit
    always_comb begin
        w_hi_an  = c_AN_HI;
        w_hi_seg = f_decode(r_hi);
`ifdef LEAD_BLANK_EN
        if (r_hi == 4'h0) begin
            w_hi_an  = c_AN_OFF;
            w_hi_seg = c_SEG_OFF;
        end
`endif
    end

    // Input sampling and high-nibble tracking
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            r_q    <= 4'h0;
            r_co_d <= 1'b0;
            r_hi   <= 4'h0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= bus.QN;
            r_co_d <= bus.CO;
            if (bus.CLR_HI) begin
                // Clear wins; a coincident event is dropped, not deferred
                r_hi   <= 4'h0;
                r_wrap <= 1'b0;
            end else if (w_ev && bus.UPDN) begin
                r_hi   <= r_hi + 4'h1;
                r_wrap <= (r_hi == 4'hF);
            end else if (w_ev) begin
                r_hi   <= r_hi - 4'h1;
                r_wrap <= (r_hi == 4'h0);
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    // Scan prescaler and registered digit drive. Select starts at 1 so the
    // first tick after reset lands on the low digit.
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            r_pre <= '0;
            r_sel <= 1'b1;
            r_an  <= c_AN_OFF;
            r_seg <= c_SEG_OFF;
        end else begin
            if (w_tick) begin
                r_pre <= '0;
                r_sel <= ~r_sel;
                if (r_sel) begin
                    r_an  <= c_AN_LO;
                    r_seg <= f_decode(r_q);
                end else begin
                    r_an  <= w_hi_an;
                    r_seg <= w_hi_seg;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign bus.HI   = r_hi;
    assign bus.WRAP = r_wrap;
    assign bus.SEG  = r_seg;
    assign bus.AN   = r_an;

endmodule
`default_nettype wire
